// File: rtl/opf_pkg.sv
// rtl/opf_pkg.sv - shared sizes and FSM state type for the operand fetch unit
package opf_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int IDXW = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HAZ,
        ST_READ,
        ST_OUT
    } opf_state_e;

endpackage

// File: rtl/opf_scoreboard.sv
// rtl/opf_scoreboard.sv - per-register pending-write bits with two lookup ports
module opf_scoreboard
    import opf_pkg::IDXW;
#(
    parameter int NREG = opf_pkg::NREG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  logic [IDXW-1:0] set_idx,
    input  logic            clr_en,
    input  logic [IDXW-1:0] clr_idx,
    input  logic [IDXW-1:0] look1_idx,
    input  logic [IDXW-1:0] look2_idx,
    output logic            look1_pend,
    output logic            look2_pend
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Clear is applied before set so a same-cycle set on the same index wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[set_idx] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign look1_pend = pending[look1_idx];
    assign look2_pend = pending[look2_idx];

endmodule

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - decode-to-execute operand fetch with scoreboard stall
module operand_fetch_unit
    import opf_pkg::IDXW;
    import opf_pkg::opf_state_e;
    import opf_pkg::ST_IDLE;
    import opf_pkg::ST_HAZ;
    import opf_pkg::ST_READ;
    import opf_pkg::ST_OUT;
#(
    parameter int XLEN = opf_pkg::XLEN,
    parameter int NREG = opf_pkg::NREG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [IDXW-1:0] dec_rs1,
    input  logic [IDXW-1:0] dec_rs2,
    input  logic [IDXW-1:0] dec_rd,
    input  logic            dec_use_rs2,
    input  logic            dec_rd_wr,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [IDXW-1:0] op_rd,
    output logic            op_rd_wr,
    input  logic            wb_valid,
    input  logic [IDXW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [IDXW-1:0] selRS1,
    output logic [IDXW-1:0] selRS2,
    output logic [IDXW-1:0] selRD,
    output logic            reg_select,
    output logic            read_en,
    output logic            rdwrite,
    output logic [XLEN-1:0] data_in,
    input  logic [XLEN-1:0] data_out1,
    input  logic [XLEN-1:0] data_out2
);

    opf_state_e      state;
    opf_state_e      state_nxt;
    logic [IDXW-1:0] rs1_q;
    logic [IDXW-1:0] rs2_q;
    logic [IDXW-1:0] rd_q;
    logic            use_rs2_q;
    logic            rd_wr_q;
    logic            pend1;
    logic            pend2;
    logic            hazard;
    logic            set_en;

    opf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (set_en),
        .set_idx    (op_rd),
        .clr_en     (wb_valid),
        .clr_idx    (wb_rd),
        .look1_idx  (rs1_q),
        .look2_idx  (rs2_q),
        .look1_pend (pend1),
        .look2_pend (pend2)
    );

    // Lookups see the registered bits, so a writeback never bypasses into this cycle's read.
    assign hazard = pend1 || (use_rs2_q && pend2);
    assign set_en = op_valid && op_ready && op_rd_wr && (op_rd != '0);

    always_comb begin
        state_nxt  = state;
        dec_ready  = 1'b0;
        read_en    = 1'b0;
        reg_select = 1'b0;
        selRS1     = '0;
        selRS2     = '0;
        op_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                dec_ready = 1'b1;
                if (dec_valid) begin
                    state_nxt = ST_HAZ;
                end
            end
            ST_HAZ: begin
                if (!hazard) begin
                    read_en    = 1'b1;
                    reg_select = use_rs2_q;
                    selRS1     = rs1_q;
                    selRS2     = rs2_q;
                    state_nxt  = ST_READ;
                end
            end
            ST_READ: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // A reset cycle must not leak a read strobe or an operand handshake.
        if (reset) begin
            read_en    = 1'b0;
            reg_select = 1'b0;
            selRS1     = '0;
            selRS2     = '0;
            op_valid   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            use_rs2_q <= 1'b0;
            rd_wr_q   <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_rd     <= '0;
            op_rd_wr  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && dec_valid) begin
                rs1_q     <= dec_rs1;
                rs2_q     <= dec_rs2;
                rd_q      <= dec_rd;
                use_rs2_q <= dec_use_rs2;
                rd_wr_q   <= dec_rd_wr;
            end
            if (state == ST_READ) begin
                op_a     <= (rs1_q == '0) ? '0 : data_out1;
                op_b     <= (use_rs2_q && (rs2_q != '0)) ? data_out2 : '0;
                op_rd    <= rd_q;
                op_rd_wr <= rd_wr_q;
            end
        end
    end

    assign selRD   = wb_rd;
    assign data_in = wb_data;
    assign rdwrite = wb_valid && (wb_rd != '0) && !reset;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - randomized self-checking bench with register-file model
module tb_operand_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [4:0]  dec_rs1 = '0;
    logic [4:0]  dec_rs2 = '0;
    logic [4:0]  dec_rd = '0;
    logic        dec_use_rs2 = 1'b0;
    logic        dec_rd_wr = 1'b0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  op_rd;
    logic        op_rd_wr;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  selRS1;
    logic [4:0]  selRS2;
    logic [4:0]  selRD;
    logic        reg_select;
    logic        read_en;
    logic        rdwrite;
    logic [31:0] data_in;
    logic [31:0] data_out1;
    logic [31:0] data_out2;

    int compared = 0;
    int mismatched = 0;

    // Architectural view kept by the bench: register values and outstanding writes.
    bit [31:0] mrf [32];
    bit        mpend [32];

    // Register-file environment; index 0 returns junk so the unit must force zero.
    bit [31:0] rf [32];

    operand_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_use_rs2 (dec_use_rs2),
        .dec_rd_wr   (dec_rd_wr),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_rd       (op_rd),
        .op_rd_wr    (op_rd_wr),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .selRS1      (selRS1),
        .selRS2      (selRS2),
        .selRD       (selRD),
        .reg_select  (reg_select),
        .read_en     (read_en),
        .rdwrite     (rdwrite),
        .data_in     (data_in),
        .data_out1   (data_out1),
        .data_out2   (data_out2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdwrite) begin
            rf[selRD] <= data_in;
        end
        if (read_en) begin
            data_out1 <= (selRS1 == 5'd0) ? 32'hDEADBEEF : rf[selRS1];
            data_out2 <= reg_select ? ((selRS2 == 5'd0) ? 32'hDEADBEEF : rf[selRS2]) : $urandom;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_rd    = r;
        wb_data  = d;
        #1;
        check("wb_rdwrite", 32'(rdwrite), 32'(r != 5'd0));
        check("wb_selrd", 32'(selRD), 32'(r));
        check("wb_data_in", data_in, d);
        @(posedge clk);
        mpend[r] = 1'b0;
        if (r != 5'd0) mrf[r] = d;
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic exec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input bit use2, input bit rdwr, input int hold, input bit at_hs,
                        input logic [31:0] wbd);
        int cyc, nhaz, stalled, lim, n;
        bit seen, haz, did_wb;
        logic [4:0] t;
        logic [31:0] ea, eb;
        n = 0;
        while (!dec_ready && n < 20) begin
            tick();
            n++;
        end
        check("dec_ready_idle", 32'(dec_ready), 32'd1);
        check("idle_read_en", 32'(read_en), 32'd0);
        check("idle_sel", {22'd0, selRS1, selRS2}, 32'd0);
        check("idle_reg_select", 32'(reg_select), 32'd0);
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_use_rs2 = use2; dec_rd_wr = rdwr;
        dec_valid = 1'b1;
        tick();
        dec_valid = 1'b0;
        cyc = 1; nhaz = 0; stalled = 0; seen = 1'b0;
        lim = $urandom_range(1, 3);
        while (!op_valid && cyc < 80) begin
            haz = mpend[rs1] || (use2 && mpend[rs2]);
            did_wb = 1'b0;
            check("read_en", 32'(read_en), 32'(!seen && !haz));
            check("dec_ready_busy", 32'(dec_ready), 32'd0);
            if (read_en) begin
                check("sel_rs1", 32'(selRS1), 32'(rs1));
                check("sel_rs2", 32'(selRS2), 32'(rs2));
                check("reg_select", 32'(reg_select), 32'(use2));
                seen = 1'b1;
            end
            if (haz && !seen) begin
                nhaz++;
                stalled++;
                if (stalled >= lim) begin
                    t = mpend[rs1] ? rs1 : rs2;
                    wb_valid = 1'b1; wb_rd = t; wb_data = wbd;
                    @(posedge clk);
                    mpend[t] = 1'b0;
                    mrf[t] = wbd;
                    #1;
                    wb_valid = 1'b0;
                    stalled = 0;
                    did_wb = 1'b1;
                end
            end
            if (!did_wb) tick();
            cyc++;
        end
        check("op_valid", 32'(op_valid), 32'd1);
        check("latency", 32'(cyc), 32'(3 + nhaz));
        ea = (rs1 == 5'd0) ? 32'd0 : mrf[rs1];
        eb = (use2 && rs2 != 5'd0) ? mrf[rs2] : 32'd0;
        check("op_a", op_a, ea);
        check("op_b", op_b, eb);
        check("op_rd", 32'(op_rd), 32'(rd));
        check("op_rd_wr", 32'(op_rd_wr), 32'(rdwr));
        for (int i = 0; i < hold; i++) begin
            check("hold_dec_ready", 32'(dec_ready), 32'd0);
            tick();
            check("hold_op_valid", 32'(op_valid), 32'd1);
            check("hold_op_a", op_a, ea);
            check("hold_op_b", op_b, eb);
            check("hold_op_rd", {26'd0, op_rd_wr, op_rd}, {26'd0, rdwr, rd});
        end
        op_ready = 1'b1;
        if (at_hs) begin
            wb_valid = 1'b1; wb_rd = rd; wb_data = wbd;
        end
        @(posedge clk);
        if (at_hs) begin
            mpend[rd] = 1'b0;
            if (rd != 5'd0) mrf[rd] = wbd;
        end
        if (rdwr && rd != 5'd0) mpend[rd] = 1'b1;
        #1;
        op_ready = 1'b0;
        wb_valid = 1'b0;
        check("post_hs_op_valid", 32'(op_valid), 32'd0);
        check("post_hs_dec_ready", 32'(dec_ready), 32'd1);
    endtask

    initial begin
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hCAFEF00D;
        repeat (3) tick();
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        check("rst_op_rd", {26'd0, op_rd_wr, op_rd}, 32'd0);
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_rdwrite", 32'(rdwrite), 32'd0);
        wb_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_dec_ready", 32'(dec_ready), 32'd1);
        check("rst_rdwrite_off", 32'(rdwrite), 32'd0);

        wb(5'd5, 32'hA5A5A5A5);
        wb(5'd14, 32'h5A5A5A5A);
        exec(5'd5, 5'd14, 5'd0, 1'b1, 1'b0, 0, 1'b0, 32'd0);
        exec(5'd3, 5'd0, 5'd1, 1'b0, 1'b0, 0, 1'b0, 32'd0);

        exec(5'd1, 5'd2, 5'd12, 1'b0, 1'b1, 0, 1'b0, 32'd0);
        exec(5'd12, 5'd0, 5'd3, 1'b0, 1'b0, 0, 1'b0, 32'h87654321);

        wb(5'd0, 32'hFFFFFFFF);
        exec(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 0, 1'b0, 32'd0);

        exec(5'd5, 5'd14, 5'd9, 1'b1, 1'b0, 5, 1'b0, 32'd0);

        exec(5'd3, 5'd4, 5'd31, 1'b1, 1'b1, 0, 1'b1, 32'h11112222);
        exec(5'd31, 5'd0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 32'h33334444);

        // Reset while stalled on x7: the held instruction must vanish.
        exec(5'd1, 5'd0, 5'd7, 1'b0, 1'b1, 0, 1'b0, 32'd0);
        dec_rs1 = 5'd7; dec_rs2 = 5'd0; dec_rd = 5'd8; dec_use_rs2 = 1'b0; dec_rd_wr = 1'b1;
        dec_valid = 1'b1;
        tick();
        dec_valid = 1'b0;
        check("haz_stall", 32'(read_en), 32'd0);
        tick();
        check("haz_stall2", 32'(read_en), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("haz_rst_op_valid", 32'(op_valid), 32'd0);
        check("haz_rst_dec_ready", 32'(dec_ready), 32'd1);
        for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
        repeat (3) begin
            tick();
            check("haz_rst_no_op", 32'(op_valid), 32'd0);
        end
        exec(5'd7, 5'd31, 5'd0, 1'b1, 1'b0, 0, 1'b0, 32'd0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                wb(5'($urandom_range(0, 31)), $urandom);
            end
            exec(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

Interface
REQ-001 SHALL have parameters:
- XLEN, 32, data width.
- NREG, 32, register count; index width 5.
REQ-002 SHALL have one clock `clk` and reset `reset`; reset is synchronous and active-high.
REQ-003 SHALL have ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- dec_valid  in  1  decoded instruction offered.
- dec_ready  out  1  unit accepts instruction.
- dec_rs1  in  5  source 1 index.
- dec_rs2  in  5  source 2 index.
- dec_rd  in  5  destination index.
- dec_use_rs2  in  1  instruction reads rs2.
- dec_rd_wr  in  1  instruction writes rd.
- op_valid  out  1  operands ready.
- op_ready  in  1  execute stage accepts operands.
- op_a  out  XLEN  rs1 value.
- op_b  out  XLEN  rs2 value.
- op_rd  out  5  destination index.
- op_rd_wr  out  1  destination write flag.
- wb_valid  in  1  writeback request, always accepted.
- wb_rd  in  5  writeback index.
- wb_data  in  XLEN  writeback value.
- selRS1, selRS2, selRD  out  5  register-file selects.
- reg_select  out  1  dual-read enable.
- read_en  out  1  register-file read strobe.
- rdwrite  out  1  register-file write strobe.
- data_in  out  XLEN  register-file write data.
- data_out1, data_out2  in  XLEN  register-file read data; valid the cycle after read_en.

Function
REQ-004 SHALL implement FSM IDLE, HAZ, READ, OUT.
REQ-005 IDLE: dec_ready=1. On dec_valid&&dec_ready, SHALL latch rs1/rs2/rd/use_rs2/rd_wr and go to HAZ. dec_ready=0 in all other states.
REQ-006 HAZ: stall while pending[rs1], or pending[rs2] when use_rs2, is set. Otherwise SHALL drive read_en=1 for exactly one cycle, with selRS1=rs1, selRS2=rs2 and reg_select=use_rs2, then go to READ.
REQ-007 READ: SHALL register op_a=data_out1 and op_b=(use_rs2 ? data_out2 : 0), then go to OUT.
REQ-008 Source index 0 SHALL yield operand 0 regardless of data_out.
REQ-009 OUT: op_valid=1; op_a, op_b, op_rd and op_rd_wr SHALL hold stable until op_valid&&op_ready, then go to IDLE.
REQ-010 Minimum latency SHALL be: accept at edge N, read_en in cycle N+1, op_valid from cycle N+3.
REQ-011 Scoreboard pending[NREG]:
- SHALL set pending[rd] on the op handshake when rd_wr=1 and rd!=0.
- SHALL clear pending[wb_rd] when wb_valid.
- pending[0] SHALL always be 0.
REQ-012 If a set and a clear target the same index in the same cycle, set SHALL win.
REQ-013 Writeback path SHALL be combinational: selRD=wb_rd, data_in=wb_data, rdwrite=wb_valid&&(wb_rd!=0).
REQ-014 wb_valid in a HAZ cycle SHALL NOT bypass; the read issues in the following cycle at the earliest.
REQ-015 No register-file read SHALL issue for a register whose pending bit is set.
REQ-016 When idle, read_en, reg_select, selRS1 and selRS2 SHALL be 0.

Reset
REQ-017 On reset the unit SHALL:
- set state to IDLE and clear pending;
- drive op_valid=0, op_a=0, op_b=0, op_rd=0, op_rd_wr=0;
- drive read_en=0 and rdwrite=0;
- drive dec_ready=1 in the first cycle after reset.
REQ-018 Reset mid-operation SHALL discard any latched or held instruction with no op handshake, and suppress any pending read strobe.

Structure
REQ-019 Package opf_pkg SHALL hold XLEN, NREG, the register-index width and the FSM state enum.
REQ-020 The scoreboard SHALL be sub-module opf_scoreboard: set/clear ports, NREG-bit vector, and two combinational lookup ports.

Verification
REQ-021 The bench SHALL cover:
- Writeback x5=0xA5A5A5A5, then instruction rs1=5, rs2=14 (x14=0x5A5A5A5A), use_rs2=1 -> read_en one cycle, op_a=A5A5A5A5, op_b=5A5A5A5A, op_valid 3 cycles after accept.
- Issue rd=12 with rd_wr=1; next instruction rs1=12 -> stalls in HAZ. wb rd=12 data 0x87654321 -> read next cycle, op_a=87654321.
- rs1=0 with x0 write attempted via wb_rd=0 data 0xFFFFFFFF -> rdwrite=0, op_a=0.
- op_ready=0 for 5 cycles in OUT -> outputs stable, dec_ready=0; then handshake -> IDLE.
- Same-cycle issue of rd=31 and wb rd=31 -> pending[31]=1 afterwards.
- reset asserted during HAZ -> op_valid=0, pending all 0, dec_ready=1 next cycle.
